ahb_resp_mux: RTL

- Data-phase return path of the AHB interconnect; it sits downstream of the address decoder.
- Registers which slave owns the current data phase from the HSEL_* lines. It then multiplexes that slave's HRDATA/HREADYOUT/HRESP onto the master-facing bus.
- Contains the default slave. Any transfer decoded as HSEL_DEFAULT gets a standard two-cycle ERROR response, and a saturating count of these errors is kept for debug.

---
 rtl/ahb_resp_mux.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ahb_resp_mux.sv
// AHB data-phase return mux with built-in default slave.
// Tracks the data-phase owner and answers unmapped transfers with a two-cycle ERROR.
module ahb_resp_mux #(
  parameter int unsigned             DATA_W    = 32,
  parameter int unsigned             ERR_CNT_W = 8,
  parameter logic [DATA_W-1:0]       DEF_RDATA = '0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL_SRAM,
  input  logic                 HSEL_SPLIT,
  input  logic                 HSEL_DEFAULT,
  input  logic [DATA_W-1:0]    HRDATA_SRAM,
  input  logic                 HREADYOUT_SRAM,
  input  logic [1:0]           HRESP_SRAM,
  input  logic [DATA_W-1:0]    HRDATA_SPLIT,
  input  logic                 HREADYOUT_SPLIT,
  input  logic [1:0]           HRESP_SPLIT,
  output logic [DATA_W-1:0]    HRDATA,
  output logic                 HREADY,
  output logic [1:0]           HRESP,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam logic [1:0] SEL_NONE  = 2'd0;
  localparam logic [1:0] SEL_SRAM  = 2'd1;
  localparam logic [1:0] SEL_SPLIT = 2'd2;
  localparam logic [1:0] SEL_DEF   = 2'd3;

  localparam logic [1:0] DS_IDLE = 2'd0;
  localparam logic [1:0] DS_ERR1 = 2'd1;
  localparam logic [1:0] DS_ERR2 = 2'd2;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  logic [1:0]           sel_q, sel_d, sel_in_c;
  logic [1:0]           ds_q, ds_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 ds_ready_c;
  logic [1:0]           ds_resp_c;

  // Address-phase select with decoder-violation priority SPLIT > SRAM > DEFAULT
  always_comb begin
    sel_in_c = SEL_NONE;
    if (HSEL_SPLIT)        sel_in_c = SEL_SPLIT;
    else if (HSEL_SRAM)    sel_in_c = SEL_SRAM;
    else if (HSEL_DEFAULT) sel_in_c = SEL_DEF;
  end

  always_comb begin
    sel_d = sel_q;
    if (HREADY) sel_d = sel_in_c;
  end

  // Default-slave response, a pure function of state so HREADY has no loop
  always_comb begin
    ds_ready_c = 1'b1;
    ds_resp_c  = RESP_OKAY;
    case (ds_q)
      DS_ERR1: begin
        ds_ready_c = 1'b0;
        ds_resp_c  = RESP_ERROR;
      end
      DS_ERR2: ds_resp_c = RESP_ERROR;
      default: ;
    endcase
  end

  always_comb begin
    ds_d      = ds_q;
    err_cnt_d = err_cnt_q;
    case (ds_q)
      DS_IDLE: if (HREADY && (sel_in_c == SEL_DEF)) ds_d = DS_ERR1;
      DS_ERR1: begin
        ds_d = DS_ERR2;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
      DS_ERR2: ds_d = (HREADY && (sel_in_c == SEL_DEF)) ? DS_ERR1 : DS_IDLE;
      default: ds_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q     <= SEL_NONE;
      ds_q      <= DS_IDLE;
      err_cnt_q <= '0;
    end else begin
      sel_q     <= sel_d;
      ds_q      <= ds_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Master-facing mux; non-selected slaves never reach the outputs
  always_comb begin
    HRDATA = DEF_RDATA;
    HREADY = 1'b1;
    HRESP  = RESP_OKAY;
    case (sel_q)
      SEL_SRAM: begin
        HRDATA = HRDATA_SRAM;
        HREADY = HREADYOUT_SRAM;
        HRESP  = HRESP_SRAM;
      end
      SEL_SPLIT: begin
        HRDATA = HRDATA_SPLIT;
        HREADY = HREADYOUT_SPLIT;
        HRESP  = HRESP_SPLIT;
      end
      SEL_DEF: begin
        HREADY = ds_ready_c;
        HRESP  = ds_resp_c;
      end
      default: ;
    endcase
  end

  assign ERR_CNT = err_cnt_q;

`ifndef SYNTHESIS
  a_hsel_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn)
    HREADY |-> $onehot0({HSEL_SPLIT, HSEL_SRAM, HSEL_DEFAULT}));
`endif

endmodule
